// File: rtl/axis_word_packer_if.sv
// ---------------------------------------------------------------------------
// axis_word_packer_if
// Bundles the narrow upstream beat stream and the wide downstream word stream
// of the word packer.
//   Upstream   : i_valid, i_data[IN_WIDTH], i_last  -> packer ; i_ready <- packer
//   Downstream : o_valid, o_data[IN_WIDTH*RATIO], o_keep[RATIO], o_last
//                packer -> ; o_ready -> packer
// Modports:
//   slave  - the packer's own view (consumes beats, produces words)
//   master - the environment's view (produces beats, consumes words)
// ---------------------------------------------------------------------------
interface axis_word_packer_if #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
);
  logic                      i_valid;
  logic [IN_WIDTH-1:0]       i_data;
  logic                      i_last;
  logic                      i_ready;
  logic                      o_valid;
  logic [IN_WIDTH*RATIO-1:0] o_data;
  logic [RATIO-1:0]          o_keep;
  logic                      o_last;
  logic                      o_ready;

  modport slave (
    input  i_valid, i_data, i_last, o_ready,
    output i_ready, o_valid, o_data, o_keep, o_last
  );

  modport master (
    output i_valid, i_data, i_last, o_ready,
    input  i_ready, o_valid, o_data, o_keep, o_last
  );
endinterface

// File: rtl/axis_word_packer.sv
// ---------------------------------------------------------------------------
// axis_word_packer
// Packs RATIO consecutive IN_WIDTH-bit beats into one IN_WIDTH*RATIO-bit word,
// little-endian (first beat in the low lane). A word is closed early by
// i_last; unfilled lanes read zero and o_keep marks the filled lanes.
// The completing beat and the accumulator load the output register on the
// same edge, so a word appears one cycle after its last beat.
// Ports:
//   aclk   - clock, rising edge
//   areset - synchronous, active-high reset
//   bus    - axis_word_packer_if.slave (upstream beats, downstream words)
// ---------------------------------------------------------------------------
module axis_word_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                 aclk,
  input  logic                 areset,
  axis_word_packer_if.slave    bus
);

  localparam int                OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int                LANE_W    = $clog2(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic [LANE_W-1:0]    lane_r;
  logic [OUT_WIDTH-1:0] acc_data_r;
  logic [RATIO-1:0]     acc_keep_r;
  logic                 o_valid_r;
  logic [OUT_WIDTH-1:0] o_data_r;
  logic [RATIO-1:0]     o_keep_r;
  logic                 o_last_r;

  logic                 i_ready_s;
  logic                 in_fire_s;
  logic                 out_fire_s;
  logic                 complete_s;
  logic [OUT_WIDTH-1:0] ins_data_s;
  logic [RATIO-1:0]     ins_keep_s;
  logic [OUT_WIDTH-1:0] merged_data_s;
  logic [RATIO-1:0]     merged_keep_s;

  // Ready whenever the output register is empty or is being drained this cycle.
  assign i_ready_s  = ~areset & (~o_valid_r | bus.o_ready);
  assign in_fire_s  = bus.i_valid & i_ready_s;
  assign out_fire_s = o_valid_r & bus.o_ready;
  assign complete_s = in_fire_s & ((lane_r == LAST_LANE) | bus.i_last);

  // Place the incoming beat into its lane; all other lanes stay zero.
  always_comb begin
    ins_data_s = '0;
    ins_keep_s = '0;
    for (int l = 0; l < RATIO; l++) begin
      ins_keep_s[l]                       = (lane_r == LANE_W'(l));
      ins_data_s[l*IN_WIDTH +: IN_WIDTH]  = bus.i_data & {IN_WIDTH{ins_keep_s[l]}};
    end
  end

  // Lanes above the current index are always zero in the accumulator, so OR merges cleanly.
  always_comb begin
    merged_data_s = acc_data_r | ins_data_s;
    merged_keep_s = acc_keep_r | ins_keep_s;
  end

  // Lane counter, accumulator and output register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      lane_r     <= '0;
      acc_data_r <= '0;
      acc_keep_r <= '0;
      o_valid_r  <= 1'b0;
      o_data_r   <= '0;
      o_keep_r   <= '0;
      o_last_r   <= 1'b0;
    end else begin
      if (complete_s) begin
        lane_r     <= '0;
        acc_data_r <= '0;
        acc_keep_r <= '0;
      end else if (in_fire_s) begin
        lane_r     <= lane_r + LANE_W'(1);
        acc_data_r <= merged_data_s;
        acc_keep_r <= merged_keep_s;
      end else begin
        lane_r     <= lane_r;
        acc_data_r <= acc_data_r;
        acc_keep_r <= acc_keep_r;
      end

      // A completion may only happen when the register is free or draining,
      // so loading here never overwrites an untransferred word.
      if (complete_s) begin
        o_valid_r <= 1'b1;
        o_data_r  <= merged_data_s;
        o_keep_r  <= merged_keep_s;
        o_last_r  <= bus.i_last;
      end else if (out_fire_s) begin
        o_valid_r <= 1'b0;
      end else begin
        o_valid_r <= o_valid_r;
      end
    end
  end

  assign bus.i_ready = i_ready_s;
  assign bus.o_valid = o_valid_r;
  assign bus.o_data  = o_data_r;
  assign bus.o_keep  = o_keep_r;
  assign bus.o_last  = o_last_r;

endmodule

// File: doc/axis_word_packer.md
AXIS_WORD_PACKER -- requirements
Module: axis_word_packer

Interface
REQ-001 Parameter IN_WIDTH, default 8, SHALL set the width of one input beat in bits.
REQ-002 Parameter RATIO, default 4, SHALL set input beats per output word; legal values are powers of two, 2 to 16.
REQ-003 aclk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 areset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 i_valid  input  1  SHALL indicate that the upstream beat is valid.
REQ-006 i_data  input  IN_WIDTH  SHALL carry the upstream beat.
REQ-007 i_last  input  1  SHALL mark the final beat of a packet.
REQ-008 i_ready  output  1  SHALL indicate that the block accepts a beat this cycle.
REQ-009 o_valid  output  1  SHALL indicate that a packed word is presented downstream.
REQ-010 o_data  output  IN_WIDTH*RATIO  SHALL carry the packed word.
REQ-011 o_keep  output  RATIO  SHALL flag which beat lanes of o_data hold valid data, one bit per lane.
REQ-012 o_last  output  1  SHALL mark the word containing the packet's final beat.
REQ-013 o_ready  input  1  SHALL indicate that downstream, typically the skid buffer, accepts the word.

Function
REQ-014 An input transfer SHALL occur when i_valid and i_ready are both high at a rising edge; an output transfer SHALL occur when o_valid and o_ready are both high.
REQ-015 i_ready SHALL be combinational: high when areset is low and either o_valid is low or o_ready is high.
REQ-016 Lane packing SHALL be little-endian: the first beat of a word goes to bits [IN_WIDTH-1:0], and beat k goes to lane k.
REQ-017 A lane index counter of log2(RATIO) bits SHALL advance on each input transfer and SHALL clear on word completion.
REQ-018 A word SHALL complete on an input transfer when the lane index equals RATIO-1 or i_last is high.
REQ-019 On completion, the accumulator contents plus the completing beat SHALL load the output register on the same edge, giving 1-cycle latency: o_valid is high the cycle after the completing beat.
REQ-020 On completion, unfilled lanes SHALL read zero in o_data; o_keep SHALL have bits 0..k set, where k is the completing lane.
REQ-021 On completion, o_last SHALL equal i_last of the completing beat.
REQ-022 While o_valid is high and o_ready is low, o_data, o_keep and o_last SHALL hold stable, and no input SHALL be accepted.
REQ-023 When an output transfer and a completing input transfer coincide, the new word SHALL load and o_valid SHALL stay high, with no bubble.
REQ-024 When an output transfer occurs with no completion in the same cycle, o_valid SHALL fall on the next edge.
REQ-025 At steady state with o_ready high, the block SHALL sustain one input beat per cycle.
REQ-026 After an i_last word, the next beat SHALL start at lane 0 with a cleared keep mask.
REQ-027 The accumulator SHALL clear its data and keep bits on every completion.

Reset
REQ-028 While areset is high at an edge: o_valid=0, o_data=0, o_keep=0, o_last=0, lane index=0, accumulator=0; i_ready SHALL be 0 throughout reset.
REQ-029 Reset asserted mid-packet SHALL discard partial data and any pending output word without emitting it.
REQ-030 The first beat after reset SHALL pack into lane 0.

Verification
REQ-031 Beats 0x11,0x22,0x33,0x44 with i_last on the 4th, o_ready=1 -> one cycle later: o_data=0x44332211, o_keep=0xF, o_last=1, for exactly one cycle.
REQ-032 Beats 0xAA,0xBB with i_last on the 2nd -> o_data=0x0000BBAA, o_keep=0x3, o_last=1.
REQ-033 Beats 0x01..0x08 back-to-back, i_last on the 8th, o_ready=1 -> 0x04030201 (keep 0xF, last 0), then 0x08070605 (keep 0xF, last 1); i_ready never falls.
REQ-034 Word pending, o_ready held low 5 cycles -> i_ready=0 and outputs stable for all 5 cycles; o_ready raised -> i_ready=1 in the same cycle, and the word is transferred once.
REQ-035 Beats 0x01..0x05, i_last on the 5th -> 0x04030201 (keep 0xF, last 0), then 0x00000005 (keep 0x1, last 1).
REQ-036 areset pulsed after 2 beats of a packet, then 0x11..0x44 with i_last -> no output from the aborted beats; a single word 0x44332211, keep 0xF.
